multicycle_alu: RTL
===================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start_i  input  1  operation request, sampled at rising edge.
REQ-005 SHALL have port ALUCtrl_i  input  3  operation code: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL, 5-7 undefined.
REQ-006 SHALL have port data1_i  input  WIDTH  first operand (minuend, multiplicand).
REQ-007 SHALL have port data2_i  input  WIDTH  second operand (subtrahend, multiplier).
REQ-008 SHALL have port ready_o  output  1  high when a request can be accepted.
REQ-009 SHALL have port valid_o  output  1  one-cycle pulse marking a new result on data_o.
REQ-010 SHALL have port data_o  output  WIDTH  registered result.
REQ-011 SHALL have port Zero_o  output  1  registered flag, high when data_o equals 0.

Function
REQ-012 SHALL implement states IDLE and MUL. ready_o = 1 only in IDLE.
REQ-013 SHALL accept a request at an edge where start_i = 1 and ready_o = 1. Operands and code are captured at that edge.
REQ-014 SHALL ignore start_i while in MUL. There is no queuing and no effect on the multiply in progress.
REQ-015 For codes 0-3, accepted at edge k, SHALL load data_o and Zero_o at edge k, hold valid_o = 1 for the following cycle, and remain in IDLE.
REQ-016 SHALL accept back-to-back codes 0-3, giving one result per cycle with valid_o high continuously.
REQ-017 For codes 5-7, SHALL behave as codes 0-3 with result 0 and Zero_o = 1.
REQ-018 SHALL compute ADD and SUB modulo 2^WIDTH. No carry or overflow outputs.
REQ-019 SHALL compute AND and OR bitwise.
REQ-020 For code 4, accepted at edge k, SHALL enter MUL. Internal state: accumulator cleared, shifted multiplicand and multiplier registers, and an iteration counter.
REQ-021 Each MUL cycle SHALL process one iteration: add the shifted multiplicand to the accumulator if the multiplier LSB is 1, shift the multiplicand left by 1, and shift the multiplier right by 1.
REQ-022 SHALL produce the lower WIDTH bits of the product, which are identical for signed and unsigned operands.
REQ-023 Without early termination, SHALL complete at edge k+WIDTH: state to IDLE, data_o and Zero_o loaded, valid_o = 1 for one cycle.
REQ-024 SHALL hold data_o and Zero_o unchanged between results. valid_o SHALL be 0 whenever no new result was loaded at the preceding edge.
REQ-025 A request presented at the completion edge of a MUL SHALL be ignored, because ready_o is 0 during that cycle.

Reset
REQ-026 When rst_i = 1 at an edge, SHALL set state IDLE, data_o = 0, Zero_o = 1, valid_o = 0, and clear all MUL registers and the counter. ready_o = 1 after that edge.
REQ-027 Reset during MUL SHALL abort the operation, produce no valid_o pulse, and leave no residual effect on the next operation.
REQ-028 rst_i SHALL take priority over start_i at the same edge.

Configuration
REQ-029 Macro ALU_MUL_EARLY_TERM_EN enables multiply early termination.
REQ-030 With the macro defined, MUL SHALL complete at the first edge where the shifted multiplier becomes 0 or the counter reaches WIDTH. Minimum latency is 1 cycle (multiplier 0 gives valid_o after edge k+1).
REQ-031 Without the macro defined, MUL latency SHALL always be WIDTH cycles, independent of operand values.

Verification
REQ-032 AND 0xF0F0F0F0, 0xFF00FF00 -> data_o 0xF000F000, Zero_o 0, valid_o one cycle after acceptance. OR of the same operands -> 0xFFF0FFF0.
REQ-033 SUB 5 - 7 -> 0xFFFFFFFE, Zero_o 0. Then, back-to-back, SUB 7 - 7 -> 0x00000000, Zero_o 1. valid_o high for two consecutive cycles.
REQ-034 MUL 6 x 7 without macro -> ready_o 0 for 32 cycles, data_o 42, valid_o pulse at edge k+32. MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001.
REQ-035 start_i held high with ADD 1 + 1 during a MUL -> ignored; only the MUL result appears, then ADD accepted once ready_o = 1.
REQ-036 rst_i pulsed at cycle 10 of MUL 3 x 5 -> no valid_o pulse, data_o 0, Zero_o 1, ready_o 1. A following ADD 2 + 3 yields 5.
REQ-037 With ALU_MUL_EARLY_TERM_EN: MUL 3 x 2 -> valid_o at edge k+2, data_o 6. MUL 9 x 0 -> valid_o at edge k+1, data_o 0, Zero_o 1.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle AND/OR/ADD/SUB and a shift-add multiplier
// that takes one iteration per clock.
// Optional macro ALU_MUL_EARLY_TERM_EN: the multiply finishes as soon as the
// remaining multiplier bits are all zero (never later than WIDTH cycles).
module multicycle_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_MUL = 3'd4
  } op_e;

  state_e           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mplr_next;
  logic             mul_done;

  // Single-cycle result for every code except MUL; undefined codes give 0
  always_comb begin
    alu_res = '0;
    case (op_e'(ALUCtrl_i))
      OP_AND:  alu_res = data1_i & data2_i;
      OP_OR:   alu_res = data1_i | data2_i;
      OP_ADD:  alu_res = data1_i + data2_i;
      OP_SUB:  alu_res = data1_i - data2_i;
      default: alu_res = '0;
    endcase
  end

  // One shift-add iteration; cnt counts iterations already done, so the
  // WIDTH-th iteration is the one taken while cnt == WIDTH-1
  always_comb begin
    acc_next  = acc + (mplr[0] ? mcand : '0);
    mplr_next = mplr >> 1;
`ifdef ALU_MUL_EARLY_TERM_EN
    mul_done  = (mplr_next == '0) || (cnt == CW'(WIDTH - 1));
`else
    mul_done  = (cnt == CW'(WIDTH - 1));
`endif
  end

  // Control FSM with registered ready/valid/result outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      data_o  <= '0;
      Zero_o  <= 1'b1;
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      cnt     <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            if (op_e'(ALUCtrl_i) == OP_MUL) begin
              state   <= S_MUL;
              ready_o <= 1'b0;
              acc     <= '0;
              mcand   <= data1_i;
              mplr    <= data2_i;
              cnt     <= '0;
            end else begin
              data_o  <= alu_res;
              Zero_o  <= (alu_res == '0);
              valid_o <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          mplr  <= mplr_next;
          cnt   <= cnt + CW'(1);
          if (mul_done) begin
            state   <= S_IDLE;
            ready_o <= 1'b1;
            data_o  <= acc_next;
            Zero_o  <= (acc_next == '0);
            valid_o <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
